// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_pkg : shared PS/2 scan-code constants, data-word layout, rx FSM  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package ps2_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    // Bit positions inside the 16-bit CPU data word
    localparam int DW_VALID = 15;
    localparam int DW_OVF   = 14;
    localparam int DW_FERR  = 13;
    localparam int DW_EXT   = 9;
    localparam int DW_BRK   = 8;
    localparam int EVT_W    = 10;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    function automatic logic is_prefix(input logic [7:0] code);
        return (code == SC_EXT) || (code == SC_BRK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : single-clock show-ahead FIFO, simultaneous push/pop      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_DEPTH);
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still accepts a push when the same cycle frees a slot
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ps2_rx_fifo : PS/2 keyboard receiver with E0/F0 folding and FIFO     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        ren,
    output logic [15:0] data,
    output logic        irq
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    logic                   w_fall;
    logic                   w_bit;

    rx_state_t   r_state;
    rx_state_t   w_state_nxt;
    logic [2:0]  r_bitcnt;
    logic [7:0]  r_shift;
    logic        r_par;
    logic [TO_W-1:0] r_to_cnt;
    logic        w_to_hit;
    logic        w_frame_good;
    logic        w_frame_bad;

    logic        r_ext;
    logic        r_brk;
    logic        r_ovf;
    logic        r_ferr;
    logic        w_push;
    logic        w_ovf_set;
    logic [EVT_W-1:0] w_head;
    logic        w_full;
    logic        w_empty;
    logic [15:0] w_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
            r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_fall   = r_clk_prev && !r_clk_sync[SYNC_STAGES-1];
    assign w_bit    = r_dat_sync[SYNC_STAGES-1];
    assign w_to_hit = (r_to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RX_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_frame_good = 1'b0;
        w_frame_bad  = 1'b0;
        if (r_state != RX_IDLE && !w_fall && w_to_hit) begin
            w_state_nxt = RX_IDLE;
            w_frame_bad = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                RX_IDLE:   if (!w_bit) w_state_nxt = RX_DATA;
                RX_DATA:   if (r_bitcnt == 3'd7) w_state_nxt = RX_PARITY;
                RX_PARITY: w_state_nxt = RX_STOP;
                RX_STOP: begin
                    w_state_nxt = RX_IDLE;
                    // Odd parity: data bits plus parity bit carry an odd number of ones
                    if (w_bit && (^{r_shift, r_par})) w_frame_good = 1'b1;
                    else                              w_frame_bad  = 1'b1;
                end
                default:   w_state_nxt = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_to_cnt <= '0;
        end else begin
            if (r_state == RX_IDLE || w_fall) r_to_cnt <= '0;
            else                              r_to_cnt <= r_to_cnt + 1'b1;
            if (w_fall) begin
                case (r_state)
                    RX_IDLE:   r_bitcnt <= '0;
                    RX_DATA: begin
                        r_shift  <= {w_bit, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end
                    RX_PARITY: r_par <= w_bit;
                    default: ;
                endcase
            end
        end
    end

    assign w_push    = w_frame_good && !is_prefix(r_shift);
    assign w_ovf_set = w_push && w_full && !ren;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_ovf  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            if (w_frame_bad) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (w_frame_good) begin
                if (r_shift == SC_EXT)      r_ext <= 1'b1;
                else if (r_shift == SC_BRK) r_brk <= 1'b1;
                else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            end
            // A new error in the clearing cycle takes priority
            if (w_ovf_set)   r_ovf <= 1'b1;
            else if (ren)    r_ovf <= 1'b0;
            if (w_frame_bad) r_ferr <= 1'b1;
            else if (ren)    r_ferr <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (EVT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata ({r_ext, r_brk, r_shift}),
        .i_pop   (ren),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_data           = '0;
        w_data[DW_VALID] = !w_empty;
        w_data[DW_OVF]   = r_ovf;
        w_data[DW_FERR]  = r_ferr;
        if (!w_empty) w_data[EVT_W-1:0] = w_head;
    end

    assign data = w_data;
    assign irq  = !w_empty;

endmodule
`default_nettype wire
